// File: rtl/clook_pipe_adder_if.sv
// Operand/result handshake bundle for the two-stage lookahead adder.
// The master side presents operands and accepts results; the slave side is the adder.
interface clook_pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/clook_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Stage 1 registers bit and 4-bit-group propagate/generate terms; stage 2 resolves
// group carries by lookahead (no ripple between groups), then intra-group carries,
// and registers sum, cout, ovf and zero. WIDTH must be a multiple of 4 in 4..64 and
// must match the WIDTH of the connected interface instance.
module clook_pipe_adder #(
    parameter int WIDTH = 16
) (
    input logic               clk,
    input logic               rst_n,
    clook_pipe_adder_if.slave bus
);
    localparam int NG = WIDTH / 4;

    logic             v1;
    logic             v2;
    logic             load_s1;
    logic             load_s2;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] g_in;
    logic [NG-1:0]    gp_in;
    logic [NG-1:0]    gg_in;

    logic [WIDTH-1:0] p1;
    logic [WIDTH-1:0] g1;
    logic [NG-1:0]    gp1;
    logic [NG-1:0]    gg1;
    logic             c0_1;

    logic [NG:0]      gc;
    logic [WIDTH-1:0] sum_n;
    logic             cmsb_n;
    logic             cout_n;
    logic             ovf_n;
    logic             zero_n;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    // Stage 2 can always drain when downstream is ready, so in_ready never looks at in_valid.
    assign bus.in_ready = !v1 || !v2 || bus.out_ready;
    assign load_s1      = bus.in_valid && bus.in_ready;
    assign load_s2      = v1 && (!v2 || bus.out_ready);

    assign bus.out_valid = v2;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

    // Subtraction is a + ~b + 1, so b is inverted up front and the +1 rides in as carry-in.
    assign b_eff = bus.sub ? ~bus.b : bus.b;
    assign p_in  = bus.a ^ b_eff;
    assign g_in  = bus.a & b_eff;

    // Collapse each 4-bit slice into a group propagate and group generate.
    always_comb begin : group_terms
        gp_in = '0;
        gg_in = '0;
        for (int k = 0; k < NG; k++) begin
            gp_in[k] = &p_in[4*k +: 4];
            gg_in[k] = g_in[4*k+3]
                     | (g_in[4*k+2] & p_in[4*k+3])
                     | (g_in[4*k+1] & p_in[4*k+2] & p_in[4*k+3])
                     | (g_in[4*k]   & p_in[4*k+1] & p_in[4*k+2] & p_in[4*k+3]);
        end
    end

    // Stage 1 register: captures the propagate/generate terms only on an accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1   <= '0;
            g1   <= '0;
            gp1  <= '0;
            gg1  <= '0;
            c0_1 <= 1'b0;
        end else if (load_s1) begin
            p1   <= p_in;
            g1   <= g_in;
            gp1  <= gp_in;
            gg1  <= gg_in;
            c0_1 <= bus.sub | bus.cin;
        end
    end

    // Stage valid bits: s1 fills on accept and empties as it moves on; s2 empties on a transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (load_s1) begin
                v1 <= 1'b1;
            end else if (load_s2) begin
                v1 <= 1'b0;
            end
            if (load_s2) begin
                v2 <= 1'b1;
            end else if (bus.out_ready) begin
                v2 <= 1'b0;
            end
        end
    end

    // Carry into each group as a flat sum of products over the registered group terms.
    always_comb begin : group_carry
        logic prod;
        logic acc;
        gc   = '0;
        prod = 1'b0;
        acc  = 1'b0;
        for (int k = 0; k <= NG; k++) begin
            prod = 1'b1;
            acc  = 1'b0;
            for (int j = k - 1; j >= 0; j--) begin
                acc  = acc | (prod & gg1[j]);
                prod = prod & gp1[j];
            end
            gc[k] = acc | (prod & c0_1);
        end
    end

    // Carry into each bit by 4-bit lookahead from its group carry, then form the sum bits.
    always_comb begin : bit_carry
        logic prod;
        logic acc;
        logic ci;
        int   base;
        sum_n  = '0;
        cmsb_n = 1'b0;
        prod   = 1'b0;
        acc    = 1'b0;
        ci     = 1'b0;
        base   = 0;
        for (int i = 0; i < WIDTH; i++) begin
            base = i - (i % 4);
            prod = 1'b1;
            acc  = 1'b0;
            for (int j = i - 1; j >= base; j--) begin
                acc  = acc | (prod & g1[j]);
                prod = prod & p1[j];
            end
            ci       = acc | (prod & gc[i/4]);
            sum_n[i] = p1[i] ^ ci;
            if (i == WIDTH - 1) begin
                cmsb_n = ci;
            end
        end
    end

    assign cout_n = gc[NG];
    assign ovf_n  = cmsb_n ^ cout_n;
    assign zero_n = (sum_n == '0);

    // Stage 2 register: result flops move only on a stage-2 load, so a stalled result holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b1;
        end else if (load_s2) begin
            sum_q  <= sum_n;
            cout_q <= cout_n;
            ovf_q  <= ovf_n;
            zero_q <= zero_n;
        end
    end
endmodule

// File: doc/clook_pipe_adder.md
CLOOK_PIPE_ADDER -- requirements
Module: clook_pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width; legal values are multiples of 4 in the range 4..64.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the operand beat is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept a beat.
REQ-006 SHALL have ports a and b, input, WIDTH bits each: the operands.
REQ-007 SHALL have port cin, input, 1 bit: carry-in, used in add mode only.
REQ-008 SHALL have port sub, input, 1 bit: 0 = add, 1 = subtract.
REQ-009 SHALL have port out_valid, output, 1 bit: the result beat is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 SHALL have port sum, output, WIDTH bits: the result.
REQ-012 SHALL have port cout, output, 1 bit: carry-out (in subtract mode, 1 means no borrow).
REQ-013 SHALL have port ovf, output, 1 bit: signed two's-complement overflow.
REQ-014 SHALL have port zero, output, 1 bit: sum == 0.

Function
REQ-015 SHALL accept a beat on any rising edge where in_valid && in_ready, and produce a transfer on any rising edge where out_valid && out_ready.
REQ-016 SHALL compute in add mode: {cout,sum} = a + b + cin.
REQ-017 SHALL compute in subtract mode: {cout,sum} = a + ~b + 1, with cin ignored.
REQ-018 SHALL compute ovf = carry into the MSB XOR cout.
REQ-019 SHALL compute zero from the final registered sum.
REQ-020 Stage 1 SHALL register the following per-bit and per-4-bit-group terms:
- per bit: p = a^b', g = a&b', where b' = sub ? ~b : b;
- per group: P = p3&p2&p1&p0, G = g3|g2&p3|g1&p2&p3|g0&p1&p2&p3;
- effective carry-in = sub ? 1 : cin.
REQ-021 Stage 2 SHALL compute the following and register them into the outputs:
- group carries by lookahead over the registered P/G, with no ripple between groups;
- intra-group carries by 4-bit lookahead;
- sum, cout, ovf and zero.
REQ-022 SHALL have a latency of exactly 2 cycles from acceptance to out_valid when out_ready is held at 1.
REQ-023 SHALL sustain a throughput of one beat per cycle when out_ready is held at 1.
REQ-024 SHALL give each stage a valid bit, with load_s2 = v1 && (!v2 || out_ready) and load_s1 = in_valid && in_ready.
REQ-025 SHALL drive in_ready = !v1 || !v2 || out_ready, combinationally, with no dependence on in_valid.
REQ-026 SHALL hold sum, cout, ovf and zero stable while out_valid && !out_ready.
REQ-027 SHALL hold a full pipeline (v1 = v2 = 1) with out_ready = 0: in_ready = 0, nothing is overwritten, and no beat is lost or duplicated.
REQ-028 SHALL handle simultaneous accept and output transfer in the same edge: both occur and occupancy is unchanged.
REQ-029 SHALL deliver results strictly in acceptance order.
REQ-030 SHALL register data only on valid-gated loads; output data flops SHALL NOT change when out_valid is 0 and no load occurs.

Reset
REQ-031 SHALL, on rst_n = 0 and asynchronously: clear v1, v2, sum, cout, ovf and stage-1 data to 0, and set zero to 1.
REQ-032 SHALL show in_ready = 1 while rst_n = 0 and in the first cycle after reset.
REQ-033 SHALL discard any beats in flight when reset asserts mid-operation, and produce no out_valid after release until a new beat is accepted.
REQ-034 SHALL take effect on the first rising clk edge after rst_n deasserts.

Verification
REQ-035 Scenario: assert reset -> out_valid = 0, sum = 0x0000, zero = 1, in_ready = 1.
REQ-036 Scenario (WIDTH = 16): add a = 0xFFFF, b = 0x0001, cin = 0, with out_ready = 1 -> 2 cycles later sum = 0x0000, cout = 1, ovf = 0, zero = 1.
REQ-037 Scenario: add a = 0x7FFF, b = 0x0000, cin = 1 -> sum = 0x8000, ovf = 1, cout = 0; this exercises the full lookahead propagate chain across all groups.
REQ-038 Scenario: sub a = 0x0005, b = 0x0007 -> sum = 0xFFFE, cout = 0, ovf = 0. Then sub a = 0x8000, b = 0x0001 -> sum = 0x7FFF, cout = 1, ovf = 1.
REQ-039 Scenario: 4 back-to-back beats with out_ready = 0 -> in_ready falls after 2 accepts; on raising out_ready, all 4 results appear in order with no gaps or loss.
REQ-040 Scenario: assert rst_n mid-stream with 2 beats in flight -> out_valid drops immediately, and no stale result emerges after release; also run a random add/sub sweep at WIDTH = 4, 16 and 64 against a reference model.
